// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer and the instruction encoder:
// state numbering, the control word layout and decode helpers.
package control_sequencer_pkg;

   localparam int SEQ_STATE_W = 6;

   // Every control state number; the encoder emits the execute entry points.
   typedef enum logic [SEQ_STATE_W-1:0] {
      S_IDLE     = 6'd0,
      S_FETCH0   = 6'd1,   // MAR <= PC
      S_FETCH1   = 6'd2,   // memory read, PC += 4
      S_FETCH2   = 6'd3,   // wait for MOC, IR <= data
      S_DECODE   = 6'd4,
      S_ADD      = 6'd10,
      S_SHIFT    = 6'd11,
      S_IMM      = 6'd12,
      S_CMP      = 6'd13,
      S_MOV      = 6'd14,
      S_LDR0     = 6'd20,
      S_LDR1     = 6'd21,
      S_LDR2     = 6'd22,
      S_LDR3     = 6'd23,
      S_STR0     = 6'd25,
      S_STR1     = 6'd26,
      S_STR2     = 6'd27,
      S_BR       = 6'd30,
      S_BR_TAKEN = 6'd31,
      S_HALT     = 6'd63
   } state_e;

   // Datapath control word, one bit per strobe.
   typedef struct packed {
      logic mar_ld;
      logic ir_ld;
      logic mdr_ld;
      logic pc_inc;
      logic pc_ld;
      logic rf_ld;
      logic flags_ld;
      logic mem_en;
      logic mem_rw;
   } ctrl_t;

   // Quiescent word: nothing loads, bus idles in read direction.
   localparam ctrl_t CTRL_IDLE = ctrl_t'(9'b0_0000_0001);

   // Encoder values the decode state may jump to.
   function automatic logic is_legal_decode(input logic [SEQ_STATE_W-1:0] s);
      case (s)
         6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd20, 6'd25, 6'd30: return 1'b1;
         default:                                              return 1'b0;
      endcase
   endfunction

   // States that stall on memory completion and run the timeout counter.
   function automatic logic is_wait_state(input state_e s);
      return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR2);
   endfunction

endpackage

// File: rtl/control_rom.sv
// Control store: maps the current state to its Moore control word.
module control_rom
   import control_sequencer_pkg::*;
(
   input  state_e state,
   output ctrl_t  ctrl
);

   // Decode state to strobes; unlisted states (idle, decode, branch test, halt) stay quiet.
   always_comb begin
      ctrl = CTRL_IDLE;
      case (state)
         S_FETCH0:   ctrl.mar_ld = 1'b1;
         S_FETCH1: begin
            ctrl.mem_en = 1'b1;
            ctrl.pc_inc = 1'b1;
         end
         S_FETCH2: begin
            ctrl.mem_en = 1'b1;
            ctrl.ir_ld  = 1'b1;   // gated by moc at the top level
         end
         S_ADD, S_SHIFT, S_IMM, S_MOV, S_LDR3:
            ctrl.rf_ld = 1'b1;
         S_CMP:      ctrl.flags_ld = 1'b1;
         S_LDR0, S_STR0:
            ctrl.mar_ld = 1'b1;
         S_LDR1:     ctrl.mem_en = 1'b1;
         S_LDR2: begin
            ctrl.mem_en = 1'b1;
            ctrl.mdr_ld = 1'b1;   // gated by moc at the top level
         end
         S_STR1:     ctrl.mdr_ld = 1'b1;
         S_STR2: begin
            ctrl.mem_en = 1'b1;
            ctrl.mem_rw = 1'b0;
         end
         S_BR_TAKEN: ctrl.pc_ld = 1'b1;
         default:    ctrl = CTRL_IDLE;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Microprogrammed sequencer: fetch/decode/execute state machine with
// memory-completion waits, a MOC timeout that halts with a sticky bus error,
// and moc-qualified loads in the memory wait states.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int STATE_W     = 6,
   parameter int MOC_TIMEOUT = 15
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [STATE_W-1:0] enc_state,
   input  logic               moc,
   input  logic               cond_true,
   output logic [STATE_W-1:0] state,
   output logic               mar_ld,
   output logic               ir_ld,
   output logic               mdr_ld,
   output logic               pc_inc,
   output logic               pc_ld,
   output logic               rf_ld,
   output logic               flags_ld,
   output logic               mem_en,
   output logic               mem_rw,
   output logic               illegal_op,
   output logic               bus_error
);

   localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);
   // Count value on the last permitted wait cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

   state_e           state_reg, state_next;
   logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic             bus_error_reg, bus_error_next;
   ctrl_t            ctrl;

   control_rom u_rom (
      .state (state_reg),
      .ctrl  (ctrl)
   );

   // State, wait counter and bus-error flag; reset may land mid-wait.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg     <= S_IDLE;
         wait_cnt_reg  <= '0;
         bus_error_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         wait_cnt_reg  <= wait_cnt_next;
         bus_error_reg <= bus_error_next;
      end
   end

   // Next state: sequencing, decode dispatch, then the wait/timeout override.
   always_comb begin
      state_next     = S_FETCH0;
      wait_cnt_next  = '0;       // cleared whenever a wait state is not held
      bus_error_next = bus_error_reg;
      illegal_op     = 1'b0;
      case (state_reg)
         S_FETCH0: state_next = S_FETCH1;
         S_FETCH1: state_next = S_FETCH2;
         S_FETCH2: state_next = S_DECODE;
         S_DECODE: begin
            if (is_legal_decode(enc_state)) begin
               state_next = state_e'(enc_state);
            end else begin
               illegal_op = 1'b1;
            end
         end
         S_LDR0:   state_next = S_LDR1;
         S_LDR1:   state_next = S_LDR2;
         S_LDR2:   state_next = S_LDR3;
         S_STR0:   state_next = S_STR1;
         S_STR1:   state_next = S_STR2;
         S_BR:     state_next = cond_true ? S_BR_TAKEN : S_FETCH0;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_FETCH0;  // idle, execute states, unreachable codes
      endcase

      // Without MOC a wait state holds, or halts once the budget is spent.
      // MOC arriving on the last allowed cycle keeps the normal transition.
      if (is_wait_state(state_reg) && !moc) begin
         if (wait_cnt_reg == CNT_LAST) begin
            state_next     = S_HALT;
            bus_error_next = 1'b1;
         end else begin
            state_next    = state_reg;
            wait_cnt_next = wait_cnt_reg + 1'b1;
         end
      end
   end

   // Moore strobes from the control store; the two memory-data loads wait for MOC.
   always_comb begin
      mar_ld   = ctrl.mar_ld;
      ir_ld    = ctrl.ir_ld & moc;
      mdr_ld   = ctrl.mdr_ld & ((state_reg != S_LDR2) | moc);
      pc_inc   = ctrl.pc_inc;
      pc_ld    = ctrl.pc_ld;
      rf_ld    = ctrl.rf_ld;
      flags_ld = ctrl.flags_ld;
      mem_en   = ctrl.mem_en;
      mem_rw   = ctrl.mem_rw;
   end

   assign state     = state_reg;
   assign bus_error = bus_error_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each cycle's expected state and strobe
// vector is queued as stimulus is applied, then popped and checked mid-cycle.
module tb_control_sequencer;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [5:0] enc_state = '0;
   logic       moc = 1'b0;
   logic       cond_true = 1'b0;
   logic [5:0] state;
   logic       mar_ld, ir_ld, mdr_ld, pc_inc, pc_ld, rf_ld, flags_ld;
   logic       mem_en, mem_rw, illegal_op, bus_error;

   control_sequencer #(.STATE_W(6), .MOC_TIMEOUT(15)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .enc_state  (enc_state),
      .moc        (moc),
      .cond_true  (cond_true),
      .state      (state),
      .mar_ld     (mar_ld),
      .ir_ld      (ir_ld),
      .mdr_ld     (mdr_ld),
      .pc_inc     (pc_inc),
      .pc_ld      (pc_ld),
      .rf_ld      (rf_ld),
      .flags_ld   (flags_ld),
      .mem_en     (mem_en),
      .mem_rw     (mem_rw),
      .illegal_op (illegal_op),
      .bus_error  (bus_error)
   );

   always #5 Clk = ~Clk;

   // Observed strobe vector and the bit masks used to build expectations.
   logic [10:0] obs;
   assign obs = {mar_ld, ir_ld, mdr_ld, pc_inc, pc_ld, rf_ld, flags_ld,
                 mem_en, mem_rw, illegal_op, bus_error};

   localparam logic [10:0] MAR = 11'h400, IR  = 11'h200, MDR = 11'h100,
                           PCI = 11'h080, PCL = 11'h040, RF  = 11'h020,
                           FL  = 11'h010, MEN = 11'h008, RD  = 11'h004,
                           ILL = 11'h002, BE  = 11'h001;

   typedef struct {
      string       tag;
      logic [5:0]  st;
      logic [10:0] sig;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   // One clock cycle: queue the expectation, drive inputs after the falling edge, check.
   task automatic cyc(input string tag, input logic rst, input logic m, input logic c,
                      input logic [5:0] e, input logic [5:0] exp_st,
                      input logic [10:0] exp_sig);
      exp_t x;
      exp_t y;
      x.tag = tag;
      x.st  = exp_st;
      x.sig = exp_sig;
      sb.push_back(x);
      @(negedge Clk);
      Reset     = rst;
      moc       = m;
      cond_true = c;
      enc_state = e;
      #1;
      y = sb.pop_front();
      n_checks++;
      assert (state === y.st) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s state: got %0d expected %0d", y.tag, state, y.st);
      end
      n_checks++;
      assert (obs === y.sig) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s strobes in state %0d: got %b expected %b", y.tag, y.st, obs, y.sig);
      end
   endtask

   // Instruction fetch with memory already complete; s4_sig covers the decode cycle.
   task automatic fetch(input string tag, input logic [5:0] e, input logic [10:0] s4_sig);
      cyc(tag, 1'b0, 1'b1, 1'b0, e, 6'd1, MAR | RD);
      cyc(tag, 1'b0, 1'b1, 1'b0, e, 6'd2, MEN | PCI | RD);
      cyc(tag, 1'b0, 1'b1, 1'b0, e, 6'd3, MEN | IR | RD);
      cyc(tag, 1'b0, 1'b1, 1'b0, e, 6'd4, s4_sig);
   endtask

   initial begin
      // Reset state and release
      cyc("reset",   1'b1, 1'b0, 1'b0, 6'd0, 6'd0, RD);
      cyc("reset",   1'b1, 1'b1, 1'b1, 6'd10, 6'd0, RD);
      cyc("release", 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, RD);

      // ADD: 1,2,3,4,10,1
      fetch("add", 6'd10, RD);
      cyc("add", 1'b0, 1'b1, 1'b0, 6'd10, 6'd10, RF | RD);

      // LDR with three moc-low cycles in S22
      fetch("ldr", 6'd20, RD);
      cyc("ldr", 1'b0, 1'b0, 1'b0, 6'd20, 6'd20, MAR | RD);
      cyc("ldr", 1'b0, 1'b0, 1'b0, 6'd20, 6'd21, MEN | RD);
      cyc("ldr", 1'b0, 1'b0, 1'b0, 6'd20, 6'd22, MEN | RD);
      cyc("ldr", 1'b0, 1'b0, 1'b0, 6'd20, 6'd22, MEN | RD);
      cyc("ldr", 1'b0, 1'b0, 1'b0, 6'd20, 6'd22, MEN | RD);
      cyc("ldr", 1'b0, 1'b1, 1'b0, 6'd20, 6'd22, MEN | MDR | RD);
      cyc("ldr", 1'b0, 1'b1, 1'b0, 6'd20, 6'd23, RF | RD);

      // STR with one moc-low cycle in S27 (write direction)
      fetch("str", 6'd25, RD);
      cyc("str", 1'b0, 1'b0, 1'b0, 6'd25, 6'd25, MAR | RD);
      cyc("str", 1'b0, 1'b0, 1'b0, 6'd25, 6'd26, MDR | RD);
      cyc("str", 1'b0, 1'b0, 1'b0, 6'd25, 6'd27, MEN);
      cyc("str", 1'b0, 1'b1, 1'b0, 6'd25, 6'd27, MEN);

      // BEQ not taken, then taken
      fetch("beq_nt", 6'd30, RD);
      cyc("beq_nt", 1'b0, 1'b1, 1'b0, 6'd30, 6'd30, RD);
      fetch("beq_t", 6'd30, RD);
      cyc("beq_t", 1'b0, 1'b1, 1'b1, 6'd30, 6'd30, RD);
      cyc("beq_t", 1'b0, 1'b1, 1'b1, 6'd30, 6'd31, PCL | RD);

      // Unsupported encoder value, then CMP
      fetch("illegal", 6'd7, ILL | RD);
      fetch("cmp", 6'd13, RD);
      cyc("cmp", 1'b0, 1'b1, 1'b0, 6'd13, 6'd13, FL | RD);

      // Reset asserted during an LDR memory wait
      fetch("rst_mid", 6'd20, RD);
      cyc("rst_mid", 1'b0, 1'b0, 1'b0, 6'd20, 6'd20, MAR | RD);
      cyc("rst_mid", 1'b0, 1'b0, 1'b0, 6'd20, 6'd21, MEN | RD);
      cyc("rst_mid", 1'b0, 1'b0, 1'b0, 6'd20, 6'd22, MEN | RD);
      cyc("rst_mid", 1'b1, 1'b0, 1'b0, 6'd20, 6'd0, RD);
      cyc("rst_mid", 1'b0, 1'b0, 1'b0, 6'd20, 6'd0, RD);

      // MOC timeout in S3: 15 wait cycles then halt with sticky bus error
      cyc("timeout", 1'b0, 1'b0, 1'b0, 6'd10, 6'd1, MAR | RD);
      cyc("timeout", 1'b0, 1'b0, 1'b0, 6'd10, 6'd2, MEN | PCI | RD);
      for (int i = 0; i < 15; i++)
         cyc("timeout_wait", 1'b0, 1'b0, 1'b0, 6'd10, 6'd3, MEN | RD);
      for (int i = 0; i < 3; i++)
         cyc("halt", 1'b0, 1'b1, 1'b1, 6'd10, 6'd63, BE | RD);
      cyc("halt_rst", 1'b1, 1'b0, 1'b0, 6'd10, 6'd0, RD);
      cyc("halt_rst", 1'b0, 1'b0, 1'b0, 6'd10, 6'd0, RD);

      // MOC on the last permitted wait cycle wins over the timeout
      cyc("late_moc", 1'b0, 1'b0, 1'b0, 6'd14, 6'd1, MAR | RD);
      cyc("late_moc", 1'b0, 1'b0, 1'b0, 6'd14, 6'd2, MEN | PCI | RD);
      for (int i = 0; i < 14; i++)
         cyc("late_moc_wait", 1'b0, 1'b0, 1'b0, 6'd14, 6'd3, MEN | RD);
      cyc("late_moc", 1'b0, 1'b1, 1'b0, 6'd14, 6'd3, MEN | IR | RD);
      cyc("late_moc", 1'b0, 1'b1, 1'b0, 6'd14, 6'd4, RD);
      cyc("late_moc", 1'b0, 1'b1, 1'b0, 6'd14, 6'd14, RF | RD);
      cyc("late_moc", 1'b0, 1'b1, 1'b0, 6'd14, 6'd1, MAR | RD);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
